// File: rtl/rom_stream.sv
// rom_stream: pipelined arithmetic-sequence ROM with valid/ready on request and response sides.
// Define ROM_STREAM_RANGE_CHK_EN to add rsp_err, flagging responses for addresses >= DEPTH.
module rom_stream #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int OFFSET = 0,
  parameter int STRIDE = 1,
  parameter int PIPE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr
`ifdef ROM_STREAM_RANGE_CHK_EN
  ,
  output logic              rsp_err
`endif
);
  localparam int P = (PIPE == 1) ? 1 : 2;
  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("rom_stream: PIPE must be 1 or 2");
  end
  function automatic logic [DATA_W-1:0] word(input int n);
    return n < DEPTH ? DATA_W'(OFFSET + n * STRIDE) : '0;
  endfunction
  logic [DATA_W-1:0] mem [2**ADDR_W];
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_mem
    assign mem[i] = word(i);
  end
  logic [P-1:0]      v;
  logic [DATA_W-1:0] d [P];
  logic [ADDR_W-1:0] a [P];
  logic go_out, go0, take;
  // With P=1 stage 0 is the output stage and go0 collapses to go_out.
  assign go_out    = v[P-1] && rsp_ready;
  assign go0       = v[0] && (!v[P-1] || go_out);
  assign req_ready = !rst && (!v[0] || go0);
  assign take      = req_valid && req_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < P; k++) begin
        d[k] <= '0;
        a[k] <= '0;
      end
    end else begin
      if (take) begin
        v[0] <= 1'b1;
        d[0] <= mem[req_addr];
        a[0] <= req_addr;
      end else if (go0) begin
        v[0] <= 1'b0;
      end
      for (int k = 1; k < P; k++) begin
        if (go0) begin
          v[k] <= 1'b1;
          d[k] <= d[k-1];
          a[k] <= a[k-1];
        end else if (go_out) begin
          v[k] <= 1'b0;
        end
      end
    end
  end
  assign rsp_valid = v[P-1];
  assign rsp_data  = v[P-1] ? d[P-1] : '0;
  assign rsp_addr  = v[P-1] ? a[P-1] : '0;
`ifdef ROM_STREAM_RANGE_CHK_EN
  logic [P-1:0] e;
  always_ff @(posedge clk) begin
    if (rst) e <= '0;
    else begin
      if (take) e[0] <= 32'(req_addr) >= DEPTH;
      for (int k = 1; k < P; k++) if (go0) e[k] <= e[k-1];
    end
  end
  assign rsp_err = v[P-1] && e[P-1];
`endif
endmodule

// File: tb/tb_rom_stream.sv
// tb_rom_stream: directed checks of rom_stream across default, offset/stride/depth and PIPE=1 builds.
module tb_rom_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [3:0] a_req_addr, a_rsp_addr;
  logic [7:0] a_rsp_data;
  logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [3:0] b_req_addr, b_rsp_addr;
  logic [7:0] b_rsp_data;
  logic       c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready;
  logic [3:0] c_req_addr, c_rsp_addr;
  logic [3:0] c_rsp_data;
`ifdef ROM_STREAM_RANGE_CHK_EN
  logic a_err, b_err, c_err;
`endif
  rom_stream u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_addr(a_rsp_addr)
`ifdef ROM_STREAM_RANGE_CHK_EN
    , .rsp_err(a_err)
`endif
  );
  rom_stream #(.OFFSET(16), .STRIDE(3), .DEPTH(12)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_addr(b_rsp_addr)
`ifdef ROM_STREAM_RANGE_CHK_EN
    , .rsp_err(b_err)
`endif
  );
  rom_stream #(.DATA_W(4), .STRIDE(5), .PIPE(1)) u_c (
    .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr),
    .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_data(c_rsp_data), .rsp_addr(c_rsp_addr)
`ifdef ROM_STREAM_RANGE_CHK_EN
    , .rsp_err(c_err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  int q [20];
  initial begin
    a_req_valid = 0; a_req_addr = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_addr = 0; b_rsp_ready = 1;
    c_req_valid = 0; c_req_addr = 0; c_rsp_ready = 1;
    tick;
    tick;
    chk("rst_ready_low", 32'(a_req_ready), 0);
    chk("rst_valid", 32'(a_rsp_valid), 0);
    chk("rst_data", 32'(a_rsp_data), 0);
    chk("rst_addr", 32'(a_rsp_addr), 0);
    rst = 0;
    #1;
    chk("ready_after_rst", 32'(a_req_ready), 1);
    // back-to-back stream, identity content, two-cycle latency
    for (int i = 0; i < 18; i++) begin
      a_req_valid = i < 16;
      a_req_addr = 4'(i);
      #1;
      chk("a_ready", 32'(a_req_ready), 1);
      chk("a_valid", 32'(a_rsp_valid), (i >= 2) ? 1 : 0);
      chk("a_data", 32'(a_rsp_data), (i >= 2) ? i - 2 : 0);
      chk("a_addr", 32'(a_rsp_addr), (i >= 2) ? i - 2 : 0);
      tick;
    end
    #1;
    chk("a_drained", 32'(a_rsp_valid), 0);
    // stall with OFFSET=0x10, STRIDE=3
    b_rsp_ready = 0;
    b_req_valid = 1; b_req_addr = 2;
    #1;
    chk("b_ready0", 32'(b_req_ready), 1);
    tick;
    b_req_addr = 5;
    #1;
    chk("b_ready1", 32'(b_req_ready), 1);
    chk("b_valid1", 32'(b_rsp_valid), 0);
    tick;
    b_req_addr = 7;
    #1;
    chk("b_ready_full", 32'(b_req_ready), 0);
    chk("b_valid_stall", 32'(b_rsp_valid), 1);
    chk("b_data_stall", 32'(b_rsp_data), 'h16);
    chk("b_addr_stall", 32'(b_rsp_addr), 2);
    tick;
    #1;
    chk("b_ready_full2", 32'(b_req_ready), 0);
    chk("b_data_hold", 32'(b_rsp_data), 'h16);
    chk("b_addr_hold", 32'(b_rsp_addr), 2);
    b_rsp_ready = 1;
    #1;
    chk("b_ready_release", 32'(b_req_ready), 1);
    chk("b_data_rel", 32'(b_rsp_data), 'h16);
    tick;
    b_req_valid = 0;
    #1;
    chk("b_valid_2nd", 32'(b_rsp_valid), 1);
    chk("b_data_2nd", 32'(b_rsp_data), 'h1f);
    chk("b_addr_2nd", 32'(b_rsp_addr), 5);
    tick;
    #1;
    chk("b_valid_3rd", 32'(b_rsp_valid), 1);
    chk("b_data_3rd", 32'(b_rsp_data), 'h25);
    chk("b_addr_3rd", 32'(b_rsp_addr), 7);
    tick;
    #1;
    chk("b_empty", 32'(b_rsp_valid), 0);
    chk("b_idle_data", 32'(b_rsp_data), 0);
    // last in-range word then out-of-range with DEPTH=12
    b_req_valid = 1; b_req_addr = 11;
    tick;
    b_req_addr = 13;
    tick;
    b_req_valid = 0;
    #1;
    chk("b_data_11", 32'(b_rsp_data), 'h31);
    chk("b_addr_11", 32'(b_rsp_addr), 11);
`ifdef ROM_STREAM_RANGE_CHK_EN
    chk("b_err_11", 32'(b_err), 0);
`endif
    tick;
    #1;
    chk("b_valid_13", 32'(b_rsp_valid), 1);
    chk("b_data_13", 32'(b_rsp_data), 0);
    chk("b_addr_13", 32'(b_rsp_addr), 13);
`ifdef ROM_STREAM_RANGE_CHK_EN
    chk("b_err_13", 32'(b_err), 1);
`endif
    tick;
    #1;
    chk("b_empty2", 32'(b_rsp_valid), 0);
`ifdef ROM_STREAM_RANGE_CHK_EN
    chk("b_err_idle", 32'(b_err), 0);
`endif
    // reset with two words in flight
    b_rsp_ready = 0;
    b_req_valid = 1; b_req_addr = 1;
    tick;
    b_req_addr = 3;
    tick;
    b_req_valid = 0;
    #1;
    chk("b_pre_rst_valid", 32'(b_rsp_valid), 1);
    chk("b_pre_rst_data", 32'(b_rsp_data), 'h13);
    chk("b_pre_rst_ready", 32'(b_req_ready), 0);
    rst = 1;
    #1;
    chk("b_rst_ready_low", 32'(b_req_ready), 0);
    tick;
    rst = 0;
    b_rsp_ready = 1;
    #1;
    chk("b_post_rst_valid", 32'(b_rsp_valid), 0);
    chk("b_post_rst_data", 32'(b_rsp_data), 0);
    chk("b_post_rst_ready", 32'(b_req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      chk("b_no_stale", 32'(b_rsp_valid), 0);
    end
    // PIPE=1, DATA_W=4, STRIDE=5: addr 9 -> 45 mod 16 = 0xD
    c_req_valid = 1; c_req_addr = 9;
    #1;
    chk("c_ready", 32'(c_req_ready), 1);
    tick;
    c_req_valid = 0;
    #1;
    chk("c_valid_9", 32'(c_rsp_valid), 1);
    chk("c_data_9", 32'(c_rsp_data), 'hd);
    chk("c_addr_9", 32'(c_rsp_addr), 9);
    tick;
    #1;
    chk("c_empty", 32'(c_rsp_valid), 0);
    c_req_valid = 1; c_req_addr = 7;
    tick;
    c_req_valid = 0;
    #1;
    chk("c_wrap_7", 32'(c_rsp_data), 3);
    tick;
    c_rsp_ready = 0;
    c_req_valid = 1; c_req_addr = 2;
    tick;
    c_req_valid = 0;
    #1;
    chk("c_ready_full", 32'(c_req_ready), 0);
    chk("c_data_2", 32'(c_rsp_data), 'ha);
    c_rsp_ready = 1;
    #1;
    chk("c_ready_rel", 32'(c_req_ready), 1);
    tick;
    #1;
    chk("c_empty2", 32'(c_rsp_valid), 0);
    // full-pipe accept/retire every cycle, no bubbles
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        q[i] = int'($urandom_range(0, 15));
        c_req_addr = 4'(q[i]);
      end
      c_req_valid = i < 20;
      #1;
      if (i < 20) chk("c_stream_ready", 32'(c_req_ready), 1);
      if (i > 0) begin
        chk("c_stream_valid", 32'(c_rsp_valid), 1);
        chk("c_stream_data", 32'(c_rsp_data), (5 * q[i-1]) % 16);
        chk("c_stream_addr", 32'(c_rsp_addr), q[i-1]);
      end
      tick;
    end
    #1;
    chk("c_stream_done", 32'(c_rsp_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
